// File: rtl/game_step_responder.sv
// game_step_responder: answers the game-control FSM's step code with the event
// pulses it waits on. It grows and replays a random symbol pattern, checks the
// player's entries against it, and times the win animation.
module game_step_responder #(
    parameter int unsigned SEQ_MAX     = 8,
    parameter int unsigned SHOW_CYCLES = 25_000_000,
    parameter int unsigned WIN_CYCLES  = 50_000_000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] step,
    input  logic       btn_valid,
    input  logic [1:0] btn_sym,
    output logic       randReady,
    output logic       done,
    output logic       done2,
    output logic       win,
    output logic       finish,
    output logic       show_valid,
    output logic [1:0] show_sym,
    output logic [4:0] level
);

    localparam int unsigned LW = 5;
    localparam int unsigned TW = $clog2(SHOW_CYCLES);
    localparam int unsigned WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

    localparam logic [LW-1:0] LEN_MAX   = LW'(SEQ_MAX);
    localparam logic [TW-1:0] TMR_LAST  = TW'(SHOW_CYCLES - 1);
    localparam logic [WW-1:0] WTMR_LAST = WW'(WIN_CYCLES - 1);

    localparam logic [3:0] ST_GEN   = 4'd1;
    localparam logic [3:0] ST_PLAY  = 4'd2;
    localparam logic [3:0] ST_FULL  = 4'd3;
    localparam logic [3:0] ST_CHECK = 4'd7;
    localparam logic [3:0] ST_WIN   = 4'd8;

    // Pattern storage is sized for the largest legal pattern so a 4-bit index is always exact.
    logic [1:0] pat [16];

    logic [3:0]    step_q;
    logic [7:0]    lfsr, lfsr_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [LW-1:0] idx, idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [LW-1:0] chk, chk_nxt;
    logic          ended, ended_nxt;
    logic [WW-1:0] wtimer, wtimer_nxt;
    logic          pat_we;
    logic          rand_nxt, done_nxt, done2_nxt, win_nxt, finish_nxt;
    logic          show_valid_nxt;
    logic [1:0]    show_sym_nxt;
    logic          entry_c;

    assign entry_c = (step != step_q);

    // Next-state and next-output decode of the current step code.
    always_comb begin
        lfsr_nxt       = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        len_nxt        = len;
        idx_nxt        = idx;
        timer_nxt      = timer;
        chk_nxt        = chk;
        ended_nxt      = ended;
        wtimer_nxt     = wtimer;
        pat_we         = 1'b0;
        rand_nxt       = 1'b0;
        done_nxt       = 1'b0;
        done2_nxt      = 1'b0;
        win_nxt        = 1'b0;
        finish_nxt     = 1'b0;
        show_valid_nxt = 1'b0;
        show_sym_nxt   = 2'b00;

        case (step)
            ST_GEN: begin
                if (entry_c) begin
                    rand_nxt = 1'b1;
                    if (len < LEN_MAX) begin
                        pat_we  = 1'b1;
                        len_nxt = len + LW'(1);
                    end
                end
                done_nxt = (len_nxt == LEN_MAX);
            end
            ST_PLAY: begin
                if (entry_c) begin
                    idx_nxt   = '0;
                    timer_nxt = '0;
                end else if (idx < len) begin
                    if (timer == TMR_LAST) begin
                        timer_nxt = '0;
                        idx_nxt   = idx + LW'(1);
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                if (idx_nxt < len) begin
                    show_valid_nxt = 1'b1;
                    show_sym_nxt   = pat[idx_nxt[3:0]];
                end
                // Pulse only on the transition into "all shown" (or at once for an empty pattern).
                done_nxt = (idx_nxt == len) && (entry_c || (idx != len));
            end
            ST_FULL: begin
            end
            ST_CHECK: begin
                if (entry_c) begin
                    chk_nxt   = '0;
                    ended_nxt = 1'b0;
                end else if (btn_valid && !ended && (chk < len)) begin
                    if (btn_sym == pat[chk[3:0]]) begin
                        chk_nxt = chk + LW'(1);
                        if (chk_nxt == len) begin
                            win_nxt   = 1'b1;
                            ended_nxt = 1'b1;
                        end
                    end else begin
                        finish_nxt = 1'b1;
                        ended_nxt  = 1'b1;
                    end
                end
            end
            ST_WIN: begin
                if (entry_c) begin
                    wtimer_nxt = '0;
                end else if (wtimer != WTMR_LAST) begin
                    wtimer_nxt = wtimer + WW'(1);
                end
                done2_nxt = (wtimer_nxt == WTMR_LAST) && (entry_c || (wtimer != WTMR_LAST));
            end
            default: begin
                len_nxt    = '0;
                idx_nxt    = '0;
                timer_nxt  = '0;
                chk_nxt    = '0;
                ended_nxt  = 1'b0;
                wtimer_nxt = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q     <= 4'd0;
            lfsr       <= LFSR_SEED;
            len        <= '0;
            idx        <= '0;
            timer      <= '0;
            chk        <= '0;
            ended      <= 1'b0;
            wtimer     <= '0;
            randReady  <= 1'b0;
            done       <= 1'b0;
            done2      <= 1'b0;
            win        <= 1'b0;
            finish     <= 1'b0;
            show_valid <= 1'b0;
            show_sym   <= 2'b00;
        end else begin
            step_q     <= step;
            lfsr       <= lfsr_nxt;
            len        <= len_nxt;
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            chk        <= chk_nxt;
            ended      <= ended_nxt;
            wtimer     <= wtimer_nxt;
            randReady  <= rand_nxt;
            done       <= done_nxt;
            done2      <= done2_nxt;
            win        <= win_nxt;
            finish     <= finish_nxt;
            show_valid <= show_valid_nxt;
            show_sym   <= show_sym_nxt;
        end
    end

    // Pattern RAM: written on GEN entry, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (pat_we) begin
            pat[len[3:0]] <= lfsr[1:0];
        end
    end

    assign level = len;

endmodule

// File: tb/tb_game_step_responder.sv
// Randomized scoreboard bench for game_step_responder.
module tb_game_step_responder;

    localparam int SEQ_MAX = 4;
    localparam int SHOW    = 3;
    localparam int WINC    = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] step = 4'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_sym = 2'b00;
    logic       randReady, done, done2, win, finish, show_valid;
    logic [1:0] show_sym;
    logic [4:0] level;

    game_step_responder #(
        .SEQ_MAX(SEQ_MAX), .SHOW_CYCLES(SHOW), .WIN_CYCLES(WINC), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .btn_valid(btn_valid), .btn_sym(btn_sym),
        .randReady(randReady), .done(done), .done2(done2), .win(win), .finish(finish),
        .show_valid(show_valid), .show_sym(show_sym), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected output vector {randReady,done,done2,win,finish,show_valid,show_sym,level} at a cycle.
    typedef struct {
        int          cyc;
        logic [12:0] vec;
    } ev_t;
    ev_t q[$];

    int         len_m = 0;
    logic [1:0] pat_m [16];
    int         rel_cyc = 0;
    int         cur_step = 0;

    // LFSR value seen at a given clock edge, counting free-running steps since reset release.
    function automatic logic [7:0] lfsr_at(int c);
        logic [7:0] v;
        bit lsb;
        v = 8'hA5;
        for (int i = 0; i < c - rel_cyc - 1; i++) begin
            lsb = v[0];
            v = v >> 1;
            if (lsb) v = v ^ 8'b1011_1000;
        end
        return v;
    endfunction

    task automatic push(int c, bit rr, bit dn, bit d2, bit wn, bit fn, bit sv, logic [1:0] ss);
        ev_t e;
        e.cyc = c;
        e.vec = {rr, dn, d2, wn, fn, sv, ss, 5'(len_m)};
        q.push_back(e);
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every active output cycle must match the scoreboard head, and vice versa.
    always @(negedge clk) begin
        logic [12:0] obs;
        if (rst) begin
            obs = {randReady, done, done2, win, finish, show_valid, show_sym, level};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_event: expected vec %h at cycle %0d, not seen", q[0].vec, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                checks++;
                if (obs !== q[0].vec) begin
                    errors++;
                    $display("FAIL event_vec: cycle %0d got %h expected %h", cyc, obs, q[0].vec);
                end
                void'(q.pop_front());
            end else if (obs[12:7] != 6'b0) begin
                checks++; errors++;
                $display("FAIL spurious_output: cycle %0d got %h expected no activity", cyc, obs);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        step = 4'd0;
        btn_valid = 1'b0;
        #1;
        check("rst_randReady", int'(randReady), 0);
        check("rst_done", int'(done), 0);
        check("rst_done2", int'(done2), 0);
        check("rst_win", int'(win), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_show_valid", int'(show_valid), 0);
        check("rst_level", int'(level), 0);
        len_m = 0;
        cur_step = 0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rel_cyc = cyc;
    endtask

    // One visit to step s lasting n clock edges; bmode: 0 random, 1 all correct + extra, 2 wrong first.
    task automatic visit(int s, int n, int bmode);
        int c0, chk, p;
        bit ended, full;
        bit bv [64];
        logic [1:0] bs [64];
        logic [7:0] lv;
        c0 = cyc + 1;
        for (int k = 0; k < 64; k++) begin bv[k] = 0; bs[k] = 2'b00; end
        if (s == 7) begin
            if (bmode == 1) begin
                for (int i = 0; i < len_m; i++) begin bv[i+1] = 1; bs[i+1] = pat_m[i]; end
                bv[len_m+2] = 1; bs[len_m+2] = pat_m[0] + 2'd1;
            end else if (bmode == 2) begin
                bv[1] = 1; bs[1] = pat_m[0] + 2'd1;
                bv[2] = 1; bs[2] = pat_m[0];
            end else begin
                p = 0;
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bv[k] = 1;
                        if (k == 0 || $urandom_range(0, 7) == 0) bs[k] = 2'($urandom_range(0, 3));
                        else begin bs[k] = pat_m[p % (len_m > 0 ? len_m : 1)]; p++; end
                    end
                end
            end
        end
        case (s)
            1: begin
                if (len_m < SEQ_MAX) begin
                    lv = lfsr_at(c0);
                    pat_m[len_m] = lv[1:0];
                    len_m++;
                end
                full = (len_m == SEQ_MAX);
                for (int k = 0; k < n; k++)
                    if (k == 0 || full) push(c0 + k, k == 0, full, 0, 0, 0, 0, 2'b00);
            end
            2: begin
                for (int k = 0; k < len_m * SHOW && k < n; k++)
                    push(c0 + k, 0, 0, 0, 0, 0, 1, pat_m[k / SHOW]);
                if (len_m * SHOW < n) push(c0 + len_m * SHOW, 0, 1, 0, 0, 0, 0, 2'b00);
            end
            3: ;
            7: begin
                chk = 0; ended = 0;
                for (int k = 1; k < n; k++) begin
                    if (bv[k] && !ended && chk < len_m) begin
                        if (bs[k] == pat_m[chk]) begin
                            chk++;
                            if (chk == len_m) begin push(c0 + k, 0, 0, 0, 1, 0, 0, 2'b00); ended = 1; end
                        end else begin
                            push(c0 + k, 0, 0, 0, 0, 1, 0, 2'b00); ended = 1;
                        end
                    end
                end
            end
            8: if (WINC - 1 < n) push(c0 + WINC - 1, 0, 0, 1, 0, 0, 0, 2'b00);
            default: len_m = 0;
        endcase
        step = 4'(s);
        cur_step = s;
        for (int k = 0; k < n; k++) begin
            btn_valid = bv[k];
            btn_sym = bs[k];
            @(negedge clk);
        end
        btn_valid = 1'b0;
        check("level", int'(level), len_m);
    endtask

    initial begin
        int steps [8];
        int s, n;
        steps[0] = 0; steps[1] = 1; steps[2] = 2; steps[3] = 3;
        steps[4] = 7; steps[5] = 8; steps[6] = 5; steps[7] = 12;
        for (int i = 0; i < 16; i++) pat_m[i] = 2'b00;
        @(negedge clk);
        do_reset();
        // Directed: growth to full, saturation, playback, win, loss, win timer, aborts, reset.
        visit(0, 3, 0);
        visit(1, 3, 0);
        visit(3, 2, 0);
        visit(1, 2, 0);
        visit(3, 1, 0);
        visit(1, 2, 0);
        visit(3, 1, 0);
        visit(1, 3, 0);
        visit(3, 1, 0);
        visit(1, 4, 0);
        visit(0, 2, 0);
        visit(2, 3, 0);
        visit(1, 2, 0);
        visit(3, 1, 0);
        visit(1, 2, 0);
        visit(2, 10, 0);
        visit(3, 1, 0);
        visit(1, 2, 0);
        visit(7, len_m + 4, 1);
        visit(3, 1, 0);
        visit(7, 6, 2);
        visit(8, 8, 0);
        visit(2, 4, 0);
        visit(1, 3, 0);
        visit(8, 3, 0);
        @(negedge clk);
        do_reset();
        // Randomized visits with occasional resets.
        for (int v = 0; v < 200; v++) begin
            do s = steps[$urandom_range(0, 7)]; while (s == cur_step);
            n = (s == 7) ? $urandom_range(2, 24) : $urandom_range(1, 16);
            visit(s, n, 0);
            if ($urandom_range(0, 29) == 0) do_reset();
        end
        step = 4'd0;
        repeat (4) @(negedge clk);
        while (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL leftover_event: expected vec %h at cycle %0d, not seen", q[0].vec, q[0].cyc);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
